// File: rtl/clk_div_sequencer_if.sv
// Control and status bundle for the clock-enable divider
// and core reset sequencer.
interface clk_div_sequencer_if #(
  parameter int NUM_CH    = 2,
  parameter int CNT_WIDTH = 5
);
  logic                          i_RUN;
  logic                          i_LOAD;
  logic [NUM_CH*CNT_WIDTH-1:0]   i_DIV;
  logic [NUM_CH-1:0]             o_CE;
  logic [NUM_CH-1:0]             o_CLKDIV;
  logic                          o_RST_OUT;
  logic                          o_READY;
  logic [CNT_WIDTH-1:0]          o_CNT0;

  modport master (
    output i_RUN, i_LOAD, i_DIV,
    input  o_CE, o_CLKDIV, o_RST_OUT,
    input  o_READY, o_CNT0
  );

  modport slave (
    input  i_RUN, i_LOAD, i_DIV,
    output o_CE, o_CLKDIV, o_RST_OUT,
    output o_READY, o_CNT0
  );
endinterface

// File: rtl/clk_div_sequencer.sv
// Multi-channel clock-enable divider with glitch-free divisor
// reload and a channel-0 paced reset-release sequencer.
module clk_div_sequencer #(
  parameter int CNT_WIDTH   = 5,
  parameter int NUM_CH      = 2,
  parameter int DEFAULT_DIV = 31,
  parameter int RST_HOLD    = 4
) (
  input  logic                 i_CLK,
  input  logic                 i_RST,
  clk_div_sequencer_if.slave   bus
);

  localparam logic [CNT_WIDTH-1:0] DIV_RST =
    CNT_WIDTH'(DEFAULT_DIV);

  localparam int HW =
    (RST_HOLD > 1) ? $clog2(RST_HOLD + 1) : 1;

  localparam logic [HW-1:0] HOLD_LAST =
    HW'((RST_HOLD > 0) ? RST_HOLD - 1 : 0);

  typedef enum logic [1:0] {
    SEQ_RESET,
    SEQ_HOLD,
    SEQ_RUN
  } seq_e;

  logic [NUM_CH-1:0]           ce_q;
  logic [NUM_CH-1:0]           lvl_q;
  logic [NUM_CH*CNT_WIDTH-1:0] cnt_all;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] div;
    logic [CNT_WIDTH-1:0] pend;
    logic                 pvld;
    logic                 ce;
    logic                 lvl;
    logic                 off;
    logic                 tc;

    assign off = (div == '0);
    assign tc  = (cnt == div);

    // Count to div, strobe and toggle at terminal count;
    // pending divisors only land on a period boundary.
    always_ff @(posedge i_CLK) begin
      if (i_RST) begin
        cnt  <= '0;
        div  <= DIV_RST;
        pend <= DIV_RST;
        pvld <= 1'b0;
        ce   <= 1'b0;
        lvl  <= 1'b0;
      end else begin
        if (off) begin
          cnt <= '0;
          ce  <= 1'b0;
          if (pvld) begin
            div  <= pend;
            pvld <= 1'b0;
          end
        end else if (bus.i_RUN) begin
          if (tc) begin
            cnt <= '0;
            ce  <= 1'b1;
            lvl <= ~lvl;
            if (pvld) begin
              div  <= pend;
              pvld <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
            ce  <= 1'b0;
          end
        end
        if (bus.i_LOAD) begin
          pend <= bus.i_DIV[k*CNT_WIDTH +: CNT_WIDTH];
          pvld <= 1'b1;
        end
      end
    end

    assign ce_q[k]  = ce;
    assign lvl_q[k] = lvl;
    assign cnt_all[k*CNT_WIDTH +: CNT_WIDTH] = cnt;
  end

  // A strobe captured while paused is held and shows up
  // on resume, so pausing never drops or repeats one.
  logic ce0;
  assign ce0 = ce_q[0] & bus.i_RUN;

  seq_e          state;
  seq_e          state_n;
  logic [HW-1:0] hold;
  logic [HW-1:0] hold_n;

  // Sequencer state and hold-strobe counter.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state <= SEQ_RESET;
      hold  <= '0;
    end else begin
      state <= state_n;
      hold  <= hold_n;
    end
  end

  // Release the core after RST_HOLD channel-0 strobes.
  always_comb begin
    state_n = state;
    hold_n  = hold;
    if (bus.i_RUN) begin
      unique case (state)
        SEQ_RESET: state_n = SEQ_HOLD;
        SEQ_HOLD: begin
          if (RST_HOLD == 0) begin
            state_n = SEQ_RUN;
          end else if (ce0) begin
            hold_n = hold + 1'b1;
            if (hold == HOLD_LAST) state_n = SEQ_RUN;
          end
        end
        SEQ_RUN: state_n = SEQ_RUN;
        default: state_n = SEQ_RESET;
      endcase
    end
  end

  assign bus.o_CE      = ce_q & {NUM_CH{bus.i_RUN}};
  assign bus.o_CLKDIV  = lvl_q;
  assign bus.o_RST_OUT = (state != SEQ_RUN);
  assign bus.o_READY   = (state == SEQ_RUN);
  assign bus.o_CNT0    = cnt_all[CNT_WIDTH-1:0];

endmodule

// File: tb/tb_clk_div_sequencer.sv
// Scoreboard bench: predicted strobe cycles are queued as
// stimulus is applied and matched against each o_CE pulse.
module tb_clk_div_sequencer;
  localparam int CW  = 5;
  localparam int NCH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errs = 0;
  int   checks = 0;
  int   q0[$];
  int   q1[$];

  clk_div_sequencer_if #(.NUM_CH(NCH), .CNT_WIDTH(CW)) bus();

  clk_div_sequencer #(
    .CNT_WIDTH(CW),
    .NUM_CH(NCH),
    .DEFAULT_DIV(31),
    .RST_HOLD(4)
  ) dut (
    .i_CLK(clk),
    .i_RST(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic push(int ch, int first, int step, int last);
    for (int c = first; c <= last; c += step) begin
      if (ch == 0) q0.push_back(c);
      else q1.push_back(c);
    end
  endtask

  task automatic wait_neg(int n);
    while (cyc < n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (bus.o_CE[0] === 1'b1) begin
      if (q0.size() == 0) chk("ce0_extra", cyc, 0);
      else chk("ce0_time", cyc, q0.pop_front());
    end
    if (bus.o_CE[1] === 1'b1) begin
      if (q1.size() == 0) chk("ce1_extra", cyc, 0);
      else chk("ce1_time", cyc, q1.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.i_RUN  = 1'b1;
    bus.i_LOAD = 1'b0;
    bus.i_DIV  = '0;
    push(0, 34, 32, 130);
    push(1, 34, 32, 130);

    wait_neg(2);
    chk("rst_cnt0", bus.o_CNT0, 0);
    chk("rst_ce", bus.o_CE, 0);
    chk("rst_clkdiv", bus.o_CLKDIV, 0);
    chk("rst_out", bus.o_RST_OUT, 1);
    chk("rst_ready", bus.o_READY, 0);
    rst = 1'b0;

    wait_neg(3);
    chk("cnt0_first", bus.o_CNT0, 1);
    wait_neg(34);
    chk("clkdiv0_rise", bus.o_CLKDIV[0], 1);
    wait_neg(65);
    chk("clkdiv0_high", bus.o_CLKDIV[0], 1);
    wait_neg(66);
    chk("clkdiv0_fall", bus.o_CLKDIV[0], 0);
    wait_neg(130);
    chk("hold_rst_out", bus.o_RST_OUT, 1);
    chk("hold_ready", bus.o_READY, 0);
    wait_neg(131);
    chk("run_rst_out", bus.o_RST_OUT, 0);
    chk("run_ready", bus.o_READY, 1);

    wait_neg(147);
    chk("pause_cnt0_in", bus.o_CNT0, 17);
    bus.i_RUN = 1'b0;
    wait_neg(150);
    chk("pause_cnt0_a", bus.o_CNT0, 17);
    chk("pause_ce", bus.o_CE, 0);
    wait_neg(167);
    chk("pause_cnt0_b", bus.o_CNT0, 17);
    bus.i_RUN = 1'b1;
    push(0, 182, 32, 182);
    push(1, 182, 32, 182);

    wait_neg(192);
    chk("load_cnt0", bus.o_CNT0, 10);
    bus.i_DIV  = {5'd7, 5'd3};
    bus.i_LOAD = 1'b1;
    push(0, 214, 4, 234);
    push(1, 214, 8, 238);
    wait_neg(193);
    bus.i_LOAD = 1'b0;

    wait_neg(213);
    chk("old_half_high", bus.o_CLKDIV[0], 1);
    wait_neg(214);
    chk("swap_low", bus.o_CLKDIV[0], 0);
    wait_neg(217);
    chk("new_half_low", bus.o_CLKDIV[0], 0);
    wait_neg(218);
    chk("new_half_rise", bus.o_CLKDIV[0], 1);

    wait_neg(233);
    bus.i_DIV  = {5'd7, 5'd1};
    bus.i_LOAD = 1'b1;
    push(0, 238, 2, 280);
    wait_neg(234);
    bus.i_LOAD = 1'b0;

    wait_neg(238);
    chk("clkdiv1_238", bus.o_CLKDIV[1], 1);
    wait_neg(239);
    bus.i_DIV  = {5'd0, 5'd1};
    bus.i_LOAD = 1'b1;
    push(1, 246, 8, 246);
    wait_neg(240);
    bus.i_LOAD = 1'b0;

    wait_neg(246);
    chk("clkdiv1_stop", bus.o_CLKDIV[1], 0);
    wait_neg(258);
    chk("clkdiv1_frozen", bus.o_CLKDIV[1], 0);
    wait_neg(259);
    bus.i_DIV  = {5'd5, 5'd1};
    bus.i_LOAD = 1'b1;
    push(1, 267, 6, 279);
    wait_neg(260);
    bus.i_LOAD = 1'b0;

    wait_neg(279);
    bus.i_DIV  = {5'd9, 5'd9};
    bus.i_LOAD = 1'b1;
    wait_neg(280);
    bus.i_LOAD = 1'b0;
    rst = 1'b1;
    push(0, 313, 32, 409);
    push(1, 313, 32, 409);
    wait_neg(281);
    rst = 1'b0;
    chk("rerst_out", bus.o_RST_OUT, 1);
    chk("rerst_ready", bus.o_READY, 0);
    chk("rerst_cnt0", bus.o_CNT0, 0);
    chk("rerst_clkdiv", bus.o_CLKDIV, 0);

    wait_neg(409);
    chk("rehold_rst_out", bus.o_RST_OUT, 1);
    wait_neg(410);
    chk("rerun_rst_out", bus.o_RST_OUT, 0);
    chk("rerun_ready", bus.o_READY, 1);

    wait_neg(420);
    chk("q0_left", q0.size(), 0);
    chk("q1_left", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
